// File: rtl/pos_counter_if.sv
// pos_counter_if: bus-side snapshot handshake and flag group for pos_counter
//   master (bus consumer): drives snapshot, snap_ack, clear_flags
//   slave  (counter)     : drives count_snap, snap_valid, overflow, underflow
interface pos_counter_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   snapshot;
  logic                   snap_ack;
  logic                   clear_flags;
  logic [COUNT_WIDTH-1:0] count_snap;
  logic                   snap_valid;
  logic                   overflow;
  logic                   underflow;
  modport master (
    output snapshot, snap_ack, clear_flags,
    input  count_snap, snap_valid, overflow, underflow
  );
  modport slave (
    input  snapshot, snap_ack, clear_flags,
    output count_snap, snap_valid, overflow, underflow
  );
endinterface

// File: rtl/pos_counter.sv
// pos_counter: signed up/down position accumulator with snapshot handshake, sticky limit flags and compare strobe
//   clk, reset (async, active-low)
//   i_inc_counter / i_dec_counter : one-cycle count strobes
//   i_clear / i_load / i_load_value : synchronous clear and preload (clear has priority)
//   i_compare_value / i_compare_en  : compare target and enable
//   o_count / o_compare_match       : registered count and one-cycle match strobe
//   bus (slave)                     : snapshot/ack handshake, sticky flags, flag clear
module pos_counter #(
  parameter int COUNT_WIDTH = 32,
  parameter int SATURATE    = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_inc_counter,
  input  logic                          i_dec_counter,
  input  logic                          i_clear,
  input  logic                          i_load,
  input  logic signed [COUNT_WIDTH-1:0] i_load_value,
  input  logic signed [COUNT_WIDTH-1:0] i_compare_value,
  input  logic                          i_compare_en,
  output logic signed [COUNT_WIDTH-1:0] o_count,
  output logic                          o_compare_match,
  pos_counter_if.slave                  bus
);
  localparam logic signed [COUNT_WIDTH-1:0] MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
  localparam logic signed [COUNT_WIDTH-1:0] MIN = {1'b1, {(COUNT_WIDTH-1){1'b0}}};
  localparam logic signed [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  typedef enum logic {SNAP_EMPTY, SNAP_FULL} snap_state_t;
  logic signed [COUNT_WIDTH-1:0] r_count;
  logic signed [COUNT_WIDTH-1:0] r_count_snap;
  logic                          r_snap_valid;
  logic                          r_overflow;
  logic                          r_underflow;
  logic                          r_compare_match;
  snap_state_t                   r_snap_state;
  logic                          w_cmd;
  logic                          w_inc;
  logic                          w_dec;
  logic                          w_ovf;
  logic                          w_unf;
  logic signed [COUNT_WIDTH-1:0] w_next;
  // Simultaneous inc and dec cancel; any clear/load discards the strobes entirely.
  assign w_cmd = i_clear | i_load;
  assign w_inc = i_inc_counter & ~i_dec_counter & ~w_cmd;
  assign w_dec = i_dec_counter & ~i_inc_counter & ~w_cmd;
  assign w_ovf = w_inc & (r_count == MAX);
  assign w_unf = w_dec & (r_count == MIN);
  // Plain +/-1 wraps two's-complement on its own; saturation only needs a hold.
  always_comb begin
    w_next = r_count;
    w_next = i_clear                               ? '0           :
             i_load                                ? i_load_value :
             ((w_ovf | w_unf) && (SATURATE != 0))  ? r_count      :
             w_inc                                 ? r_count + ONE :
             w_dec                                 ? r_count - ONE :
                                                     r_count;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count         <= '0;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
      r_compare_match <= 1'b0;
    end else begin
      r_count         <= w_next;
      // A new event outranks a coincident clear_flags.
      r_overflow      <= w_ovf | (r_overflow & ~bus.clear_flags);
      r_underflow     <= w_unf | (r_underflow & ~bus.clear_flags);
      // Pulses only when the count actually moves onto the target.
      r_compare_match <= i_compare_en & (w_next == i_compare_value) & (w_next != r_count);
    end
  end
  // Snapshot handshake: a new capture always wins over a coincident ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap_state <= SNAP_EMPTY;
      r_count_snap <= '0;
      r_snap_valid <= 1'b0;
    end else if (bus.snapshot) begin
      r_snap_state <= SNAP_FULL;
      r_count_snap <= r_count;
      r_snap_valid <= 1'b1;
    end else if (r_snap_state == SNAP_FULL && bus.snap_ack) begin
      r_snap_state <= SNAP_EMPTY;
      r_snap_valid <= 1'b0;
    end
  end
  assign o_count         = r_count;
  assign o_compare_match = r_compare_match;
  assign bus.count_snap  = r_count_snap;
  assign bus.snap_valid  = r_snap_valid;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
endmodule

// File: tb/tb_pos_counter.sv
// tb_pos_counter: directed self-checking bench for pos_counter, wrap (w) and saturate (s) variants side by side
module tb_pos_counter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inc = 1'b0, dec = 1'b0, clr = 1'b0, ld = 1'b0, cen = 1'b0;
  logic       snap = 1'b0, ack = 1'b0, cf = 1'b0;
  logic [7:0] lv = '0, cv = '0;
  logic [7:0] cnt_w, cnt_s;
  logic       match_w, match_s;
  int         n_chk = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  pos_counter_if #(.COUNT_WIDTH(8)) bw ();
  pos_counter_if #(.COUNT_WIDTH(8)) bs ();
  assign bw.snapshot = snap;
  assign bw.snap_ack = ack;
  assign bw.clear_flags = cf;
  assign bs.snapshot = snap;
  assign bs.snap_ack = ack;
  assign bs.clear_flags = cf;
  pos_counter #(.COUNT_WIDTH(8), .SATURATE(0)) u_w (
    .clk(clk), .reset(reset), .i_inc_counter(inc), .i_dec_counter(dec),
    .i_clear(clr), .i_load(ld), .i_load_value(lv), .i_compare_value(cv),
    .i_compare_en(cen), .o_count(cnt_w), .o_compare_match(match_w), .bus(bw));
  pos_counter #(.COUNT_WIDTH(8), .SATURATE(1)) u_s (
    .clk(clk), .reset(reset), .i_inc_counter(inc), .i_dec_counter(dec),
    .i_clear(clr), .i_load(ld), .i_load_value(lv), .i_compare_value(cv),
    .i_compare_en(cen), .o_count(cnt_s), .o_compare_match(match_s), .bus(bs));
  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    inc = 0; dec = 0; clr = 0; ld = 0; snap = 0; ack = 0; cf = 0;
  endtask
  task automatic do_load(input logic [7:0] v);
    lv = v; ld = 1; tick();
  endtask
  initial begin
    #1;
    chk8("rst_cnt_w", cnt_w, 8'h00);
    chk8("rst_cnt_s", cnt_s, 8'h00);
    chk1("rst_valid", bw.snap_valid, 1'b0);
    chk1("rst_ovf", bw.overflow, 1'b0);
    chk1("rst_unf", bs.underflow, 1'b0);
    chk1("rst_match", match_w, 1'b0);
    #2 reset = 1;
    for (int i = 0; i < 5; i++) begin inc = 1; tick(); end
    for (int i = 0; i < 2; i++) begin dec = 1; tick(); end
    chk8("updown_w", cnt_w, 8'd3);
    chk8("updown_s", cnt_s, 8'd3);
    chk1("updown_ovf", bw.overflow, 1'b0);
    chk1("updown_unf", bw.underflow, 1'b0);
    do_load(8'd127);
    chk8("ld_max", cnt_w, 8'h7f);
    chk1("ld_max_noflag", bw.overflow, 1'b0);
    inc = 1; tick();
    chk8("ovf_wrap", cnt_w, 8'h80);
    chk8("ovf_sat", cnt_s, 8'h7f);
    chk1("ovf_w", bw.overflow, 1'b1);
    chk1("ovf_s", bs.overflow, 1'b1);
    tick();
    chk1("ovf_sticky", bw.overflow, 1'b1);
    cf = 1; tick();
    chk1("ovf_clr_w", bw.overflow, 1'b0);
    chk1("ovf_clr_s", bs.overflow, 1'b0);
    do_load(8'h80);
    chk1("ld_min_noflag", bw.underflow, 1'b0);
    dec = 1; cf = 1; tick();
    chk8("unf_wrap", cnt_w, 8'h7f);
    chk8("unf_sat", cnt_s, 8'h80);
    chk1("unf_beats_clr_w", bw.underflow, 1'b1);
    chk1("unf_beats_clr_s", bs.underflow, 1'b1);
    chk1("unf_no_ovf", bw.overflow, 1'b0);
    cf = 1; tick();
    chk1("unf_clr", bw.underflow, 1'b0);
    cv = 8'd10; cen = 1;
    do_load(8'd9);
    chk1("cmp_ld9", match_w, 1'b0);
    inc = 1; tick();
    chk8("cmp_cnt", cnt_w, 8'd10);
    chk1("cmp_hit", match_w, 1'b1);
    tick();
    chk1("cmp_one_cycle", match_w, 1'b0);
    inc = 1; dec = 1; tick();
    chk8("incdec_cnt", cnt_w, 8'd10);
    chk1("incdec_nomatch", match_w, 1'b0);
    do_load(8'd10);
    chk1("ld_same_nomatch", match_w, 1'b0);
    cv = 8'd0; tick();
    chk1("cv_change_nomatch", match_w, 1'b0);
    clr = 1; tick();
    chk8("clr_cnt", cnt_w, 8'd0);
    chk1("clr_match", match_w, 1'b1);
    cv = 8'd127;
    do_load(8'd126);
    inc = 1; tick();
    chk1("sat_hit_w", match_w, 1'b1);
    chk1("sat_hit_s", match_s, 1'b1);
    inc = 1; tick();
    chk8("sat_hold", cnt_s, 8'h7f);
    chk1("sat_hold_nomatch", match_s, 1'b0);
    chk1("wrap_nomatch", match_w, 1'b0);
    cen = 0; cf = 1; tick();
    do_load(8'd42);
    snap = 1; tick();
    chk8("snap42", bw.count_snap, 8'd42);
    chk1("snap42_valid", bw.snap_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin inc = 1; tick(); end
    chk8("snap_hold", bw.count_snap, 8'd42);
    chk8("cnt45", cnt_w, 8'd45);
    snap = 1; ack = 1; tick();
    chk8("snap_ack_same", bw.count_snap, 8'd45);
    chk1("snap_ack_valid", bw.snap_valid, 1'b1);
    ack = 1; tick();
    chk1("ack_clears", bw.snap_valid, 1'b0);
    ack = 1; tick();
    chk1("ack_empty", bw.snap_valid, 1'b0);
    snap = 1; inc = 1; tick();
    chk8("snap_pre_update", bw.count_snap, 8'd45);
    chk8("snap_pre_cnt", cnt_w, 8'd46);
    ack = 1; tick();
    do_load(8'd20);
    clr = 1; lv = 8'd7; ld = 1; inc = 1; tick();
    chk8("clr_ld_inc", cnt_w, 8'd0);
    chk1("clr_ld_inc_ovf", bw.overflow, 1'b0);
    chk1("clr_ld_inc_unf", bw.underflow, 1'b0);
    do_load(8'd127);
    inc = 1; snap = 1; tick();
    chk1("pre_rst_valid", bw.snap_valid, 1'b1);
    chk1("pre_rst_ovf", bw.overflow, 1'b1);
    #2 reset = 0;
    #1;
    chk8("arst_cnt_w", cnt_w, 8'h00);
    chk8("arst_cnt_s", cnt_s, 8'h00);
    chk8("arst_snap", bw.count_snap, 8'h00);
    chk1("arst_valid", bw.snap_valid, 1'b0);
    chk1("arst_ovf_w", bw.overflow, 1'b0);
    chk1("arst_ovf_s", bs.overflow, 1'b0);
    chk1("arst_unf", bw.underflow, 1'b0);
    chk1("arst_match", match_w, 1'b0);
    #2 reset = 1;
    tick();
    chk8("post_rst_cnt", cnt_w, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pos_counter.md
Name: pos_counter

Overview:
- Signed up/down position accumulator sitting directly downstream of the slow-pulse count FSM.
- Consumes its one-cycle inc_counter/dec_counter strobes and maintains a signed position count.
- Provides clear/preload, a snapshot register with valid/ack handshake for the bus interface, sticky overflow/underflow flags and a compare-match strobe.

Parameters:
- COUNT_WIDTH, 32, width of the signed count, snapshot, preload and compare values.
- SATURATE, 0, limit behaviour: 0 = wrap two's-complement, 1 = hold at limit.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- inc_counter  input  1  one-cycle strobe, count +1
- dec_counter  input  1  one-cycle strobe, count -1
- clear  input  1  synchronous clear of count to 0
- load  input  1  synchronous preload of count from load_value
- load_value  input  COUNT_WIDTH  signed preload value
- compare_value  input  COUNT_WIDTH  signed compare target
- compare_en  input  1  enables compare_match generation
- snapshot  input  1  request capture of count into count_snap
- snap_ack  input  1  consumer acknowledge, clears snap_valid
- clear_flags  input  1  clears overflow and underflow
- count  output  COUNT_WIDTH  current signed count, registered
- count_snap  output  COUNT_WIDTH  captured count
- snap_valid  output  1  count_snap holds unread data
- overflow  output  1  sticky, increment past most-positive value
- underflow  output  1  sticky, decrement past most-negative value
- compare_match  output  1  one-cycle strobe, count became equal to compare_value

Behaviour:
- Reset (reset = 0, asynchronous):
  - count, count_snap, snap_valid, overflow, underflow and compare_match all go to 0.
- Count update priority, evaluated each clock:
  - clear > load > (inc_counter XOR dec_counter).
  - inc_counter and dec_counter both high: net zero, count unchanged, no flag effect.
  - clear or load active: inc/dec strobes in that cycle are discarded and no flags are set.
- Latency: count reflects a strobe or command on the clock edge that samples it (1 cycle).
- Limits: MAX = 2^(COUNT_WIDTH-1)-1, MIN = -2^(COUNT_WIDTH-1).
  - Increment at MAX:
    - SATURATE=0: count wraps to MIN.
    - SATURATE=1: count holds MAX.
    - overflow is set in both cases.
  - Decrement at MIN:
    - SATURATE=0: count wraps to MAX.
    - SATURATE=1: count holds MIN.
    - underflow is set in both cases.
  - Loading MAX or MIN never sets a flag.
- Flags:
  - Sticky until clear_flags.
  - clear_flags coincident with a new overflow/underflow event: the event wins and the flag stays 1.
- compare_match:
  - Registered; high for exactly the one cycle in which the updated count first appears.
  - Requires compare_en = 1, next count == compare_value, and next count != current count.
  - Applies to strobes, load and clear alike.
  - Count holding at the compare value (including saturated hold) gives no further pulses.
  - A change of compare_value alone does not pulse.
- Snapshot handshake (two states):
  - SNAP_EMPTY → SNAP_FULL on snapshot: count_snap takes the pre-update count (the value of count in the request cycle) and snap_valid = 1.
  - SNAP_FULL → SNAP_EMPTY on snap_ack without snapshot.
  - snapshot while SNAP_FULL: count_snap is overwritten and snap_valid stays 1.
  - snapshot and snap_ack together: the new capture wins and snap_valid stays 1.
  - snap_ack while SNAP_EMPTY: ignored.
- Reset mid-operation: all state returns to reset values immediately; any pending snapshot is lost.

Test Plan (COUNT_WIDTH=8 unless stated):
- Reset, then 5 inc_counter strobes, then 2 dec_counter strobes → count = 3 one cycle after the last strobe; flags = 0.
- load_value=127, load; then 1 inc with SATURATE=0 → count = -128 and overflow = 1. Repeat with SATURATE=1 → count = 127 and overflow = 1. clear_flags → overflow = 0.
- count=-128, dec coincident with clear_flags (SATURATE=0) → count = 127, underflow = 1 (event beats clear).
- compare_value=10, compare_en=1, count=9: inc → compare_match high one cycle with count=10. inc+dec together at 10 → no pulse. load 10 while already at 10 → no pulse.
- count=42: snapshot → count_snap = 42, snap_valid = 1. Further incs leave count_snap at 42. snapshot and snap_ack same cycle at count=45 → count_snap = 45, snap_valid = 1. snap_ack → snap_valid = 0.
- clear, load(7) and inc in the same cycle from count=20 → count = 0, no flags. Then assert reset mid-run with snap_valid=1 → all outputs 0 asynchronously, before the next clock edge.
